muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, alongside the ALU. It consumes the same rs1/rs2 operands and funct3 encoding. It returns a 32-bit result after a fixed multi-cycle latency through a start/done handshake. While it runs, the pipeline control stalls issue; its result is muxed into writeback next to the ALU result.

## Interface
- No parameters; operand width fixed at 32, iteration count fixed at 32.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  start request; accepted only when ready_o=1.
- kill_i  in  1  flush; aborts any operation in flight.
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  in  32  operand A (dividend / multiplicand).
- rs2_i  in  32  operand B (divisor / multiplier).
- ready_o  out  1  unit is idle and can accept.
- busy_o  out  1  operation in flight; drives the pipeline stall.
- done_o  out  1  one-cycle pulse; result_o is valid in this cycle.
- Result_o  out  32  result; holds its value until the next done_o.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE: ready_o=1. On valid_i, latch op, operand signs and absolute values, then go to CALC with counter=0.
  - CALC: one step per cycle, counter 0..31; leave to FIX when counter=31.
  - FIX: apply sign correction, select hi/lo or quotient/remainder, register Result_o.
  - DONE: done_o=1; go to IDLE on the next edge.
- Multiply: unsigned shift-add on a 64-bit accumulator.
  - Signedness per op: MUL/MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU both unsigned.
  - Negate the 64-bit product when the operand signs differ (signed operands only).
  - MUL returns product[31:0]; the other three return product[63:32].
- Divide: restoring, unsigned core on magnitudes.
  - Quotient is negated if the signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
- Special cases are resolved in IDLE and skip CALC (IDLE→FIX→DONE):
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV → 0x80000000, REM → 0.
- kill_i:
  - In any non-IDLE state: return to IDLE next edge, no done_o, Result_o unchanged.
  - In IDLE: takes priority over valid_i (no accept).
- valid_i while busy is ignored; it is not queued.

## Timing
- Reset values: state=IDLE, ready_o=1, busy_o=0, done_o=0, Result_o=0, counter=0, internal accumulators 0.
- Normal operation:
  - Accept at edge E.
  - CALC occupies the cycles after edges E..E+31.
  - FIX occupies the cycle after edge E+32.
  - done_o is high in the cycle after edge E+33, i.e. 34 cycles from accept.
  - ready_o returns at edge E+34.
- Special cases: done_o is high in the cycle after edge E+2 (latency 3).
- busy_o = !ready_o, combinational from the state.
- Back-to-back: the earliest next accept is edge E+34 (E+3 for special cases).
- Asynchronous reset mid-operation: immediate return to the reset values; the partial result is discarded.
- Result_o changes only on the edge entering DONE.

## Structure
- The shared package (alongside define.sv macros) holds:
  - the funct3 codes for the M ops (`MUL` … `REMU`);
  - the state enum;
  - the constants INT_MIN=0x80000000 and ITER=32.
- One sub-module, `muldiv_iter_32bit`: a combinational single step, selected by a mul/div flag.
  - Mul step: conditional add, then shift.
  - Div step: shift, trial subtract, restore.
  - The FSM, counter, sign fix-up and special-case logic stay in the top level.

## Test plan
- MUL 7×(−3): rs1=0x7, rs2=0xFFFFFFFD → Result_o=0xFFFFFFEB; done_o exactly 34 cycles after accept.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/−1 → 0x80000000; REM of the same → 0; each with done_o at latency 3.
- Abort and reset mid-operation:
  - kill_i at CALC counter=10 → IDLE next edge, no done_o, previous Result_o held.
  - rst_ni low mid-CALC → ready_o=1 and Result_o=0 immediately.
  - valid_i held high during busy → no second accept until ready_o.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 codes, FSM state encoding, constants and sign helpers.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam int          ITER    = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic [31:0] neg_if32(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg_if64(input logic [63:0] v, input logic n);
        return n ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter_32bit.sv
// One combinational iteration of the shared datapath: a shift-add multiply
// step or a restoring divide step on the {acc_hi, acc_lo} register pair.
module muldiv_iter_32bit
    import muldiv_pkg::*;
(
    input  logic        is_div_i,
    input  logic [31:0] acc_hi_i,
    input  logic [31:0] acc_lo_i,
    input  logic [31:0] opnd_i,
    output logic [31:0] acc_hi_o,
    output logic [31:0] acc_lo_o
);

    logic [32:0] sum_s;
    logic [32:0] shifted_s;
    logic [31:0] diff_s;
    logic        ge_s;

    // Multiply: acc_lo holds the remaining multiplier bits; divide: acc_hi is the
    // partial remainder and acc_lo shifts dividend bits out / quotient bits in.
    always_comb begin
        sum_s     = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : 33'd0);
        shifted_s = {acc_hi_i, acc_lo_i[31]};
        ge_s      = (shifted_s >= {1'b0, opnd_i});
        // Whenever ge_s holds the true difference is below opnd_i, so 32 bits suffice.
        diff_s    = shifted_s[31:0] - opnd_i;
        if (is_div_i) begin
            acc_hi_o = ge_s ? diff_s : shifted_s[31:0];
            acc_lo_o = {acc_lo_i[30:0], ge_s};
        end else begin
            acc_hi_o = sum_s[32:1];
            acc_lo_o = {sum_s[0], acc_lo_i[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: start/done handshake, 32 datapath
// iterations, sign fix-up and early resolution of divide special cases.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic        kill_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] Result_o
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic        neg_q, neg_d;
    logic        spec_q, spec_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] result_q, result_d;

    logic        a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [31:0] mag_a_s, mag_b_s;
    logic [31:0] step_hi_s, step_lo_s;
    logic [63:0] prod_fix_s;
    logic [31:0] fix_s;

    muldiv_iter_32bit u_iter (
        .is_div_i (op_q[2]),
        .acc_hi_i (hi_q),
        .acc_lo_i (lo_q),
        .opnd_i   (opnd_q),
        .acc_hi_o (step_hi_s),
        .acc_lo_o (step_lo_s)
    );

    // Operand sign decode and magnitudes for the incoming request.
    always_comb begin
        a_signed_s = (op_i != F3_MULHU) && (op_i != F3_DIVU) && (op_i != F3_REMU);
        b_signed_s = (op_i == F3_MUL) || (op_i == F3_MULH) ||
                     (op_i == F3_DIV) || (op_i == F3_REM);
        a_neg_s    = a_signed_s & rs1_i[31];
        b_neg_s    = b_signed_s & rs2_i[31];
        mag_a_s    = neg_if32(rs1_i, a_neg_s);
        mag_b_s    = neg_if32(rs2_i, b_neg_s);
    end

    // Final result selection with sign correction; special cases bypass the datapath.
    always_comb begin
        prod_fix_s = neg_if64({hi_q, lo_q}, neg_q);
        case (op_q)
            F3_MUL:                      fix_s = prod_fix_s[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_s = prod_fix_s[63:32];
            F3_DIV, F3_DIVU:             fix_s = neg_if32(lo_q, neg_q);
            F3_REM, F3_REMU:             fix_s = neg_if32(hi_q, neg_q);
            default:                     fix_s = 32'd0;
        endcase
        if (spec_q) begin
            fix_s = lo_q;
        end else begin
            fix_s = fix_s;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        spec_d   = spec_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (!kill_i && valid_i) begin
                    op_d   = op_i;
                    hi_d   = 32'd0;
                    cnt_d  = 5'd0;
                    spec_d = 1'b0;
                    neg_d  = (op_i == F3_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);
                    if (op_i[2] && (rs2_i == 32'd0)) begin
                        spec_d  = 1'b1;
                        lo_d    = op_i[1] ? rs1_i : 32'hFFFF_FFFF;
                        state_d = S_FIX;
                    end else if (((op_i == F3_DIV) || (op_i == F3_REM)) &&
                                 (rs1_i == INT_MIN) && (rs2_i == 32'hFFFF_FFFF)) begin
                        spec_d  = 1'b1;
                        lo_d    = op_i[1] ? 32'd0 : INT_MIN;
                        state_d = S_FIX;
                    end else begin
                        lo_d    = op_i[2] ? mag_a_s : mag_b_s;
                        opnd_d  = op_i[2] ? mag_b_s : mag_a_s;
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    hi_d = step_hi_s;
                    lo_d = step_lo_s;
                    if (cnt_q == 5'(ITER - 1)) begin
                        cnt_d   = 5'd0;
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            S_FIX: begin
                // Special cases dwell two cycles here to keep their latency fixed at 3.
                if (kill_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end else if (spec_q && (cnt_q == 5'd0)) begin
                    cnt_d = 5'd1;
                end else begin
                    result_d = fix_s;
                    cnt_d    = 5'd0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            spec_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            opnd_q   <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            spec_q   <= spec_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign Result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency, kill,
// async reset and held-valid behaviour with hand-computed expectations.
module tb_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        kill_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        ready_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] Result_o;

    int passed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    muldiv_unit dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .kill_i   (kill_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .Result_o (Result_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string tag);
        int cyc;
        @(negedge clk_i);
        valid_i = 1'b1;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (done_o !== 1'b1 && cyc < 60);
        chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, " result"}, Result_o, exp);
        @(negedge clk_i);
        chk({tag, " done pulse"}, {31'd0, done_o}, 32'd0);
        chk({tag, " ready after"}, {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        int cyc;
        int rdy;
        int ndone;
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        kill_i  = 1'b0;
        op_i    = 3'd0;
        rs1_i   = 32'd0;
        rs2_i   = 32'd0;
        #12;
        chk("reset ready", {31'd0, ready_o}, 32'd1);
        chk("reset busy", {31'd0, busy_o}, 32'd0);
        chk("reset done", {31'd0, done_o}, 32'd0);
        chk("reset result", Result_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "MUL 7x-3");
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "MULH min");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "MULHU max");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "MULHSU");
        run_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, "DIV -7/2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, "REM -7/2");
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 34, "DIVU 100/7");
        run_op(3'b111, 32'd100, 32'd7, 32'd2, 34, "REMU 100/7");
        run_op(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 3, "DIV 5/0");
        run_op(3'b110, 32'd5, 32'd0, 32'd5, 3, "REM 5/0");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3, "DIV ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 3, "REM ovf");

        // kill together with valid in IDLE: no accept
        @(negedge clk_i);
        valid_i = 1'b1;
        kill_i  = 1'b1;
        op_i    = 3'b000;
        rs1_i   = 32'd3;
        rs2_i   = 32'd3;
        @(negedge clk_i);
        valid_i = 1'b0;
        kill_i  = 1'b0;
        chk("kill idle ready", {31'd0, ready_o}, 32'd1);
        chk("kill idle busy", {31'd0, busy_o}, 32'd0);

        // valid held through the whole operation: exactly one accept
        @(negedge clk_i);
        valid_i = 1'b1;
        op_i    = 3'b101;
        rs1_i   = 32'd100;
        rs2_i   = 32'd7;
        @(posedge clk_i);
        cyc = 0;
        rdy = 0;
        do begin
            @(negedge clk_i);
            cyc++;
            if (ready_o) rdy++;
        end while (done_o !== 1'b1 && cyc < 60);
        valid_i = 1'b0;
        chk("held valid latency", 32'(cyc), 32'd34);
        chk("held valid result", Result_o, 32'd14);
        chk("held valid ready cycles", 32'(rdy), 32'd0);
        @(negedge clk_i);
        chk("held valid idle", {31'd0, ready_o}, 32'd1);

        // kill at CALC counter=10
        @(negedge clk_i);
        valid_i = 1'b1;
        op_i    = 3'b000;
        rs1_i   = 32'd7;
        rs2_i   = 32'd3;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (11) @(negedge clk_i);
        chk("kill busy before", {31'd0, busy_o}, 32'd1);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        chk("kill ready", {31'd0, ready_o}, 32'd1);
        chk("kill done", {31'd0, done_o}, 32'd0);
        chk("kill result held", Result_o, 32'd14);
        ndone = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o) ndone++;
        end
        chk("kill no done", 32'(ndone), 32'd0);

        // asynchronous reset mid-CALC
        @(negedge clk_i);
        valid_i = 1'b1;
        op_i    = 3'b000;
        rs1_i   = 32'd7;
        rs2_i   = 32'd3;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("pre-reset busy", {31'd0, busy_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async reset ready", {31'd0, ready_o}, 32'd1);
        chk("async reset busy", {31'd0, busy_o}, 32'd0);
        chk("async reset result", Result_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_op(3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 34, "MULHU after reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
